// File: rtl/tod_pkg.sv
// Shared types and constants for the time-of-day clock: digit-select encoding,
// per-digit limits and the write-legality rule used for both time and alarm digits.
package tod_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    SEL_S2   = 3'd0,
    SEL_S1   = 3'd1,
    SEL_M2   = 3'd2,
    SEL_M1   = 3'd3,
    SEL_H2   = 3'd4,
    SEL_H1   = 3'd5,
    SEL_BAD6 = 3'd6,
    SEL_BAD7 = 3'd7
  } sel_e;

  localparam bcd_t MAX_S2      = 4'd9;
  localparam bcd_t MAX_S1      = 4'd5;
  localparam bcd_t MAX_M2      = 4'd9;
  localparam bcd_t MAX_M1      = 4'd5;
  localparam bcd_t MAX_H2      = 4'd9;
  localparam bcd_t MAX_H1      = 4'd2;
  localparam bcd_t MAX_H2_WRAP = 4'd3;

  // Hour digits are checked against the other hour digit so 24..29 can never be stored.
  function automatic logic digit_legal(input sel_e s, input bcd_t v, input bcd_t h1, input bcd_t h2);
    logic ok;
    ok = 1'b0;
    case (s)
      SEL_S2:  ok = (v <= MAX_S2);
      SEL_M2:  ok = (v <= MAX_M2);
      SEL_S1:  ok = (v <= MAX_S1);
      SEL_M1:  ok = (v <= MAX_M1);
      SEL_H2:  ok = (h1 == MAX_H1) ? (v <= MAX_H2_WRAP) : (v <= MAX_H2);
      SEL_H1:  ok = (v < MAX_H1) || ((v == MAX_H1) && (h2 <= MAX_H2_WRAP));
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit: parallel load, increment with carry-out at MAX, and an
// external early-wrap request used by the units-of-hours digit at 23.
module bcd_digit
  import tod_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk_out,
  input  logic rst,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic inc,
  input  logic wrap_at,
  output bcd_t q,
  output bcd_t nxt,
  output logic co
);

  assign co = inc & ((q == MAX) | wrap_at);

  always_comb begin
    nxt = q;
    if (ld)       nxt = ld_val;
    else if (inc) nxt = co ? 4'd0 : q + 4'd1;
  end

  always_ff @(posedge clk_out) begin
    if (rst) q <= '0;
    else     q <= nxt;
  end

endmodule

// File: rtl/tod_clock.sv
// BCD time-of-day clock with prescaler, digit writes and 12/24-hour display.
// Optional alarm compare is built when TOD_ALARM_EN is defined.
module tod_clock
  import tod_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1,
  parameter int PRESCALE_W    = 1
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [2:0] sel,
  input  bcd_t       loadin,
  input  logic       alm_load,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output bcd_t       h1,
  output bcd_t       h2,
  output bcd_t       m1,
  output bcd_t       m2,
  output bcd_t       s1,
  output bcd_t       s2,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_wrap,
  output logic       load_err,
  output logic       alarm
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SEC - 1);

  logic [PRESCALE_W-1:0] presc;
  logic       hold, tick, wr_ok, alm_err, mode_q;
  logic [5:0] ld_dig;
  bcd_t       s2_q, s1_q, m2_q, m1_q, h2_q, h1_q;
  bcd_t       s2_n, s1_n, m2_n, m1_n, h2_n, h1_n;
  logic       s2_co, s1_co, m2_co, m1_co, h2_co, h1_co;
  logic [4:0] hr24, hr12;

  // A write in progress freezes the prescaler, so a coinciding tick is dropped.
  assign tick   = run & ~hold & (presc == PRESC_LAST);
  assign wr_ok  = load & digit_legal(sel_e'(sel), loadin, h1_q, h2_q);
  assign ld_dig = wr_ok ? (6'd1 << sel) : 6'd0;

  bcd_digit #(.MAX(MAX_S2)) u_s2 (.clk_out(clk_out), .rst(rst), .ld(ld_dig[SEL_S2]), .ld_val(loadin),
    .inc(tick),  .wrap_at(1'b0), .q(s2_q), .nxt(s2_n), .co(s2_co));
  bcd_digit #(.MAX(MAX_S1)) u_s1 (.clk_out(clk_out), .rst(rst), .ld(ld_dig[SEL_S1]), .ld_val(loadin),
    .inc(s2_co), .wrap_at(1'b0), .q(s1_q), .nxt(s1_n), .co(s1_co));
  bcd_digit #(.MAX(MAX_M2)) u_m2 (.clk_out(clk_out), .rst(rst), .ld(ld_dig[SEL_M2]), .ld_val(loadin),
    .inc(s1_co), .wrap_at(1'b0), .q(m2_q), .nxt(m2_n), .co(m2_co));
  bcd_digit #(.MAX(MAX_M1)) u_m1 (.clk_out(clk_out), .rst(rst), .ld(ld_dig[SEL_M1]), .ld_val(loadin),
    .inc(m2_co), .wrap_at(1'b0), .q(m1_q), .nxt(m1_n), .co(m1_co));
  bcd_digit #(.MAX(MAX_H2)) u_h2 (.clk_out(clk_out), .rst(rst), .ld(ld_dig[SEL_H2]), .ld_val(loadin),
    .inc(m1_co), .wrap_at((h1_q == MAX_H1) && (h2_q == MAX_H2_WRAP)), .q(h2_q), .nxt(h2_n), .co(h2_co));
  bcd_digit #(.MAX(MAX_H1)) u_h1 (.clk_out(clk_out), .rst(rst), .ld(ld_dig[SEL_H1]), .ld_val(loadin),
    .inc(h2_co), .wrap_at(1'b0), .q(h1_q), .nxt(h1_n), .co(h1_co));

  always_ff @(posedge clk_out) begin
    if (rst) begin
      presc     <= '0;
      mode_q    <= 1'b0;
      sec_pulse <= 1'b0;
      day_wrap  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (run && !hold) presc <= (presc == PRESC_LAST) ? '0 : presc + PRESCALE_W'(1);
      mode_q    <= mode_12h;
      sec_pulse <= tick;
      day_wrap  <= h1_co;
      load_err  <= (load & ~wr_ok) | alm_err;
    end
  end

  // 12-hour view is derived from the stored 24-hour digits only.
  always_comb begin
    hr24 = 5'(h1_q) * 5'd10 + 5'(h2_q);
    hr12 = hr24;
    pm   = 1'b0;
    h1   = h1_q;
    h2   = h2_q;
    if (mode_q) begin
      pm = (hr24 >= 5'd12);
      if (hr24 == 5'd0)       hr12 = 5'd12;
      else if (hr24 > 5'd12)  hr12 = hr24 - 5'd12;
      h1 = (hr12 >= 5'd10) ? 4'd1 : 4'd0;
      h2 = (hr12 >= 5'd10) ? 4'(hr12 - 5'd10) : 4'(hr12);
    end
  end

  assign m1 = m1_q;
  assign m2 = m2_q;
  assign s1 = s1_q;
  assign s2 = s2_q;

`ifdef TOD_ALARM_EN
  bcd_t al_h1, al_h2, al_m1, al_m2;
  logic al_ok, al_set;

  assign hold    = load | alm_load;
  assign al_ok   = alm_load && (sel inside {SEL_M2, SEL_M1, SEL_H2, SEL_H1})
                   && digit_legal(sel_e'(sel), loadin, al_h1, al_h2);
  assign alm_err = alm_load & ~al_ok;
  // Match on the value the digits take this edge so alarm rises with sec_pulse.
  assign al_set  = tick & alarm_en & (s2_n == 4'd0) & (s1_n == 4'd0) & (m2_n == al_m2)
                   & (m1_n == al_m1) & (h2_n == al_h2) & (h1_n == al_h1);

  always_ff @(posedge clk_out) begin
    if (rst) begin
      al_h1 <= '0;
      al_h2 <= '0;
      al_m1 <= '0;
      al_m2 <= '0;
      alarm <= 1'b0;
    end else begin
      if (al_ok) begin
        case (sel_e'(sel))
          SEL_M2:  al_m2 <= loadin;
          SEL_M1:  al_m1 <= loadin;
          SEL_H2:  al_h2 <= loadin;
          SEL_H1:  al_h1 <= loadin;
          default: ;
        endcase
      end
      if (al_set)                      alarm <= 1'b1;
      else if (alarm_ack || !alarm_en) alarm <= 1'b0;
    end
  end
`else
  logic unused_alarm;
  assign hold         = load;
  assign alm_err      = 1'b0;
  assign alarm        = 1'b0;
  assign unused_alarm = ^{alm_load, alarm_en, alarm_ack, s2_n, s1_n, m2_n, m1_n, h2_n, h1_n};
`endif

endmodule

// File: tb/tb_tod_clock.sv
// Self-checking bench for tod_clock: directed scenarios plus randomized stimulus
// against a seconds-of-day reference model.
module tb_tod_clock;

  localparam int TPS = 4;

  typedef int digs_t [6];

  logic       clk_out = 1'b0;
  logic       rst = 1'b1, run = 1'b0, mode_12h = 1'b0, load = 1'b0;
  logic [2:0] sel = '0;
  logic [3:0] loadin = '0;
  logic       alm_load = 1'b0, alarm_en = 1'b0, alarm_ack = 1'b0;
  logic [3:0] h1, h2, m1, m2, s1, s2;
  logic       pm, sec_pulse, day_wrap, load_err, alarm;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int    m_t = 0, m_presc = 0;
  logic  m_mode = 1'b0, m_sp = 1'b0, m_dw = 1'b0, m_le = 1'b0, m_alarm = 1'b0;
  digs_t m_al = '{0, 0, 0, 0, 0, 0};

  tod_clock #(.TICKS_PER_SEC(TPS), .PRESCALE_W(2)) dut (
    .clk_out(clk_out), .rst(rst), .run(run), .mode_12h(mode_12h), .load(load),
    .sel(sel), .loadin(loadin), .alm_load(alm_load), .alarm_en(alarm_en),
    .alarm_ack(alarm_ack), .h1(h1), .h2(h2), .m1(m1), .m2(m2), .s1(s1), .s2(s2),
    .pm(pm), .sec_pulse(sec_pulse), .day_wrap(day_wrap), .load_err(load_err),
    .alarm(alarm)
  );

  initial forever #5 clk_out = ~clk_out;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic split(input int t, output digs_t d);
    d[0] = t % 10;
    d[1] = (t / 10) % 6;
    d[2] = (t / 60) % 10;
    d[3] = (t / 600) % 6;
    d[4] = (t / 3600) % 10;
    d[5] = t / 36000;
  endtask

  function automatic int to_secs(input digs_t d);
    return d[0] + 10 * d[1] + 60 * d[2] + 600 * d[3] + 3600 * d[4] + 36000 * d[5];
  endfunction

  function automatic bit time_ok(input digs_t d);
    return d[0] <= 9 && d[1] <= 5 && d[2] <= 9 && d[3] <= 5 && d[4] <= 9 && d[5] <= 2
           && (d[5] * 10 + d[4]) <= 23;
  endfunction

  task automatic model_edge();
    digs_t d, a;
    bit    hold, tk, hit;
    if (rst) begin
      m_t = 0; m_presc = 0; m_mode = 0; m_sp = 0; m_dw = 0; m_le = 0; m_alarm = 0;
      m_al = '{0, 0, 0, 0, 0, 0};
      return;
    end
    m_sp = 0; m_dw = 0; m_le = 0; hit = 0;
`ifdef TOD_ALARM_EN
    hold = load || alm_load;
`else
    hold = load;
`endif
    tk = run && !hold && (m_presc == TPS - 1);
    if (run && !hold) m_presc = (m_presc + 1) % TPS;
    if (load) begin
      split(m_t, d);
      if (int'(sel) <= 5) d[int'(sel)] = int'(loadin);
      if (int'(sel) <= 5 && time_ok(d)) m_t = to_secs(d);
      else m_le = 1;
    end else if (tk) begin
      m_t  = (m_t + 1) % 86400;
      m_sp = 1;
      m_dw = (m_t == 0);
      hit  = alarm_en && (m_t == to_secs(m_al));
    end
`ifdef TOD_ALARM_EN
    if (alm_load) begin
      a = m_al;
      if (int'(sel) >= 2 && int'(sel) <= 5) a[int'(sel)] = int'(loadin);
      if (int'(sel) >= 2 && int'(sel) <= 5 && time_ok(a)) m_al = a;
      else m_le = 1;
    end
    if (hit) m_alarm = 1;
    else if (alarm_ack || !alarm_en) m_alarm = 0;
`else
    m_alarm = hit & 1'b0;
`endif
    m_mode = mode_12h;
  endtask

  function automatic logic [31:0] model_vec();
    int   h, mi, s, hd;
    logic p;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    s  = m_t % 60;
    hd = h;
    p  = 1'b0;
    if (m_mode) begin
      p  = (h >= 12);
      hd = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    end
    return {3'b0, 4'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            p, m_sp, m_dw, m_le, m_alarm};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {3'b0, h1, h2, m1, m2, s1, s2, pm, sec_pulse, day_wrap, load_err, alarm};
  endfunction

  function automatic logic [31:0] digits();
    return {8'b0, h1, h2, m1, m2, s1, s2};
  endfunction

  task automatic cyc();
    @(posedge clk_out);
    model_edge();
    #1;
    check_eq("state", dut_vec(), model_vec());
  endtask

  task automatic write_digit(input int s, input int v);
    load = 1'b1; sel = 3'(s); loadin = 4'(v);
    cyc();
    load = 1'b0;
  endtask

  task automatic write_alarm(input int s, input int v);
    alm_load = 1'b1; sel = 3'(s); loadin = 4'(v);
    cyc();
    alm_load = 1'b0;
  endtask

  task automatic run_to_pulse(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      seen = sec_pulse;
    end
    check_eq("pulse_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    // reset
    cyc(); cyc();
    check_eq("reset_state", dut_vec(), 32'd0);
    rst = 1'b0;

    // free run from reset: pulse every TPS cycles
    run = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("no_early_pulse", 32'(sec_pulse), 32'd0);
    cyc();
    check_eq("first_sec", {sec_pulse, digits()}, {1'b1, 32'h000001});
    for (int i = 0; i < 4; i++) cyc();
    check_eq("second_sec", {sec_pulse, digits()}, {1'b1, 32'h000002});

    // end-of-day wrap
    run = 1'b0;
    write_digit(5, 2); write_digit(4, 3); write_digit(3, 5);
    write_digit(2, 9); write_digit(1, 5); write_digit(0, 9);
    check_eq("loaded_235959", digits(), 32'h235959);
    run = 1'b1;
    run_to_pulse(8);
    check_eq("wrap_time", digits(), 32'h000000);
    check_eq("wrap_pulse", 32'(day_wrap), 32'd1);
    run = 1'b0;
    cyc();
    check_eq("wrap_one_cycle", 32'(day_wrap), 32'd0);

    // rejected writes
    write_digit(5, 1); write_digit(4, 5);
    write_digit(5, 2);
    check_eq("h1_reject_err", 32'(load_err), 32'd1);
    check_eq("h1_keep", 32'(h1), 32'd1);
    cyc();
    check_eq("err_one_cycle", 32'(load_err), 32'd0);
    write_digit(6, 3);
    check_eq("sel6_err", 32'(load_err), 32'd1);
    write_digit(2, 10);
    check_eq("m2_range_err", 32'(load_err), 32'd1);

    // 12-hour display
    mode_12h = 1'b1;
    write_digit(5, 1); write_digit(4, 3); write_digit(3, 0);
    write_digit(2, 5); write_digit(1, 0); write_digit(0, 0);
    check_eq("pm_1305", {pm, digits()}, {1'b1, 32'h010500});
    write_digit(5, 0); write_digit(4, 0); write_digit(3, 1); write_digit(2, 0);
    check_eq("midnight_12", {pm, digits()}, {1'b0, 32'h121000});
    mode_12h = 1'b0;
    cyc();
    check_eq("mode_back_24", {pm, digits()}, {1'b0, 32'h001000});

    // reset mid-prescale with a write pending
    run = 1'b1;
    cyc(); cyc();
    rst = 1'b1; load = 1'b1; sel = 3'd0; loadin = 4'd5;
    cyc();
    check_eq("rst_over_load", dut_vec(), 32'd0);
    rst = 1'b0; load = 1'b0;
    run_to_pulse(8);
    check_eq("rst_full_second", digits(), 32'h000001);

    // alarm
    run = 1'b0;
`ifdef TOD_ALARM_EN
    write_alarm(5, 0); write_alarm(4, 7); write_alarm(3, 3); write_alarm(2, 0);
    write_alarm(1, 0);
    check_eq("alm_sel_err", 32'(load_err), 32'd1);
    write_digit(5, 0); write_digit(4, 7); write_digit(3, 2);
    write_digit(2, 9); write_digit(1, 5); write_digit(0, 9);
    alarm_en = 1'b1;
    cyc();
    check_eq("alarm_idle", 32'(alarm), 32'd0);
    run = 1'b1;
    run_to_pulse(8);
    check_eq("alarm_rise", {alarm, digits()}, {1'b1, 32'h073000});
    run = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("alarm_hold", 32'(alarm), 32'd1);
    alarm_ack = 1'b1;
    cyc();
    alarm_ack = 1'b0;
    check_eq("alarm_ack_clear", 32'(alarm), 32'd0);
`else
    alarm_en = 1'b1; alm_load = 1'b1; sel = 3'd2; loadin = 4'd1;
    cyc();
    alm_load = 1'b0;
    check_eq("alarm_tied", {alarm, load_err}, 2'b00);
`endif

    // randomized traffic against the model
    write_digit(5, 2); write_digit(4, 3); write_digit(3, 5); write_digit(2, 9);
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 149) == 0);
      run       = ($urandom_range(0, 7) != 0);
      load      = ($urandom_range(0, 9) == 0);
      sel       = 3'($urandom_range(0, 7));
      loadin    = 4'($urandom_range(0, 15));
      alm_load  = ($urandom_range(0, 15) == 0);
      alarm_en  = ($urandom_range(0, 3) != 0);
      alarm_ack = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 31) == 0) mode_12h = ~mode_12h;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
